// File: rtl/poly_voice_allocator.sv
// Polyphonic MIDI note allocator: running-status note-on/off parser feeding a
// free-first, oldest-steal voice assigner with per-voice pitch, velocity, gate and trigger.
module poly_voice_allocator #(
    parameter int unsigned NUM_VOICES   = 4,
    parameter int unsigned MIDI_CHANNEL = 0,
    parameter bit          OMNI         = 1'b0
) (
    input  logic                      inCLK,
    input  logic                      inRESET,
    input  logic [7:0]                inMidiByte,
    input  logic                      inMidiReady,
    output logic [7*NUM_VOICES-1:0]   outFrequencyIndex,
    output logic [7*NUM_VOICES-1:0]   outVelocity,
    output logic [NUM_VOICES-1:0]     outPlaying,
    output logic [NUM_VOICES-1:0]     outNoteOnStrobe
);
    localparam int unsigned AW = $clog2(NUM_VOICES);

    typedef enum logic [1:0] {StIdle, StData1, StData2} state_e;

    state_e     state_q;
    logic [7:0] rs_q;
    logic [6:0] d1_q;

    // Completed, channel-accepted note message, applied to the voices one cycle later.
    logic       msg_valid_q;
    logic       msg_on_q;
    logic [6:0] msg_note_q;
    logic [6:0] msg_vel_q;

    logic [6:0]    idx_q   [NUM_VOICES];
    logic [6:0]    vel_q   [NUM_VOICES];
    logic [AW-1:0] age_q   [NUM_VOICES];
    logic [NUM_VOICES-1:0] play_q;
    logic [NUM_VOICES-1:0] strobe_q;

    logic          accept;
    logic [AW-1:0] sel;
    logic          found;

    assign accept = ((rs_q[7:4] == 4'h9) || (rs_q[7:4] == 4'h8)) &&
                    (OMNI || (rs_q[3:0] == 4'(MIDI_CHANNEL)));

    always_ff @(posedge inCLK or posedge inRESET) begin
        if (inRESET) begin
            state_q     <= StIdle;
            rs_q        <= '0;
            d1_q        <= '0;
            msg_valid_q <= 1'b0;
            msg_on_q    <= 1'b0;
            msg_note_q  <= '0;
            msg_vel_q   <= '0;
        end else begin
            msg_valid_q <= 1'b0;
            if (inMidiReady) begin
                if (inMidiByte >= 8'hF8) begin
                    // realtime: transparent to the parser
                end else if (inMidiByte >= 8'hF0) begin
                    rs_q    <= '0;
                    state_q <= StIdle;
                end else if (inMidiByte[7]) begin
                    rs_q    <= inMidiByte;
                    state_q <= StData1;
                end else begin
                    case (state_q)
                        StData1: begin
                            if (rs_q[7:4] != 4'hC && rs_q[7:4] != 4'hD) begin
                                d1_q    <= inMidiByte[6:0];
                                state_q <= StData2;
                            end
                        end
                        StData2: begin
                            state_q <= StData1;
                            if (accept) begin
                                msg_valid_q <= 1'b1;
                                msg_on_q    <= (rs_q[7:4] == 4'h9) && (inMidiByte[6:0] != 7'd0);
                                msg_note_q  <= d1_q;
                                msg_vel_q   <= inMidiByte[6:0];
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    // Voice choice: retrigger match, then lowest free voice, then the oldest.
    always_comb begin
        sel   = '0;
        found = 1'b0;
        for (int unsigned v = 0; v < NUM_VOICES; v++) begin
            if (!found && play_q[v] && idx_q[v] == msg_note_q) begin
                sel   = AW'(v);
                found = 1'b1;
            end
        end
        for (int unsigned v = 0; v < NUM_VOICES; v++) begin
            if (!found && !play_q[v]) begin
                sel   = AW'(v);
                found = 1'b1;
            end
        end
        for (int unsigned v = 0; v < NUM_VOICES; v++) begin
            if (!found && age_q[v] == AW'(NUM_VOICES - 1)) begin
                sel   = AW'(v);
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge inCLK or posedge inRESET) begin
        if (inRESET) begin
            for (int unsigned v = 0; v < NUM_VOICES; v++) begin
                idx_q[v] <= '0;
                vel_q[v] <= '0;
                age_q[v] <= AW'(v);
            end
            play_q   <= '0;
            strobe_q <= '0;
        end else begin
            strobe_q <= '0;
            if (msg_valid_q) begin
                if (msg_on_q) begin
                    for (int unsigned v = 0; v < NUM_VOICES; v++) begin
                        if (age_q[v] < age_q[sel]) age_q[v] <= age_q[v] + 1'b1;
                    end
                    age_q[sel]    <= '0;
                    idx_q[sel]    <= msg_note_q;
                    vel_q[sel]    <= msg_vel_q;
                    play_q[sel]   <= 1'b1;
                    strobe_q[sel] <= 1'b1;
                end else begin
                    for (int unsigned v = 0; v < NUM_VOICES; v++) begin
                        if (play_q[v] && idx_q[v] == msg_note_q) play_q[v] <= 1'b0;
                    end
                end
            end
        end
    end

    for (genvar v = 0; v < NUM_VOICES; v++) begin : g_out
        assign outFrequencyIndex[7*v +: 7] = idx_q[v];
        assign outVelocity[7*v +: 7]       = vel_q[v];
    end
    assign outPlaying      = play_q;
    assign outNoteOnStrobe = strobe_q;

endmodule

// File: tb/tb_poly_voice_allocator.sv
// Bench for poly_voice_allocator: directed scenarios plus random byte streams checked every
// cycle against a message-level model using an LRU list of voices.
module tb_poly_voice_allocator;
    localparam int NV = 4;
    localparam int CH = 2;

    logic              inCLK = 1'b0;
    logic              inRESET = 1'b0;
    logic [7:0]        inMidiByte = 8'h00;
    logic              inMidiReady = 1'b0;
    logic [7*NV-1:0]   outFrequencyIndex;
    logic [7*NV-1:0]   outVelocity;
    logic [NV-1:0]     outPlaying;
    logic [NV-1:0]     outNoteOnStrobe;

    int n_pass = 0;
    int n_total = 0;

    always #10 inCLK = ~inCLK;

    poly_voice_allocator #(
        .NUM_VOICES  (NV),
        .MIDI_CHANNEL(CH),
        .OMNI        (1'b0)
    ) dut (
        .inCLK            (inCLK),
        .inRESET          (inRESET),
        .inMidiByte       (inMidiByte),
        .inMidiReady      (inMidiReady),
        .outFrequencyIndex(outFrequencyIndex),
        .outVelocity      (outVelocity),
        .outPlaying       (outPlaying),
        .outNoteOnStrobe  (outNoteOnStrobe)
    );

    // Reference model state
    int m_rs, m_cnt, m_d1;
    bit p_valid, p_on;
    int p_note, p_vel;
    int m_idx[NV];
    int m_vel[NV];
    bit m_play[NV];
    bit m_strobe[NV];
    int lru[$];  // front = most recently triggered, back = steal candidate

    function automatic void model_reset();
        m_rs = 0; m_cnt = 0; m_d1 = 0; p_valid = 0; p_on = 0; p_note = 0; p_vel = 0;
        lru.delete();
        for (int i = 0; i < NV; i++) begin
            m_idx[i] = 0; m_vel[i] = 0; m_play[i] = 0; m_strobe[i] = 0;
            lru.push_back(i);
        end
    endfunction

    function automatic void model_apply();
        int v;
        for (int i = 0; i < NV; i++) m_strobe[i] = 0;
        if (p_valid) begin
            if (p_on) begin
                v = -1;
                for (int i = 0; i < NV; i++) if (v < 0 && m_play[i] && m_idx[i] == p_note) v = i;
                for (int i = 0; i < NV; i++) if (v < 0 && !m_play[i]) v = i;
                if (v < 0) v = lru[lru.size() - 1];
                for (int k = 0; k < lru.size(); k++) begin
                    if (lru[k] == v) begin
                        lru.delete(k);
                        break;
                    end
                end
                lru.push_front(v);
                m_idx[v] = p_note; m_vel[v] = p_vel; m_play[v] = 1; m_strobe[v] = 1;
            end else begin
                for (int i = 0; i < NV; i++) if (m_play[i] && m_idx[i] == p_note) m_play[i] = 0;
            end
        end
        p_valid = 0;
    endfunction

    function automatic void model_byte(input int b);
        int typ;
        if (b >= 'hF8) return;
        if (b >= 'hF0) begin m_rs = 0; m_cnt = 0; return; end
        if (b >= 'h80) begin m_rs = b; m_cnt = 0; return; end
        if (m_rs == 0) return;
        typ = m_rs / 16;
        if (typ == 12 || typ == 13) return;
        if (m_cnt == 0) begin m_d1 = b; m_cnt = 1; return; end
        m_cnt = 0;
        if ((typ == 8 || typ == 9) && (m_rs % 16) == CH) begin
            p_valid = 1; p_on = (typ == 9) && (b != 0); p_note = m_d1; p_vel = b;
        end
    endfunction

    function automatic logic [31:0] pack7(input bit sel_vel);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < NV; i++) r[7*i +: 7] = 7'(sel_vel ? m_vel[i] : m_idx[i]);
        return r;
    endfunction

    function automatic logic [31:0] pack1(input bit sel_strobe);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < NV; i++) r[i] = sel_strobe ? m_strobe[i] : m_play[i];
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic check_all(input string tag);
        check({tag, ".idx"}, 32'(outFrequencyIndex), pack7(0));
        check({tag, ".vel"}, 32'(outVelocity), pack7(1));
        check({tag, ".play"}, 32'(outPlaying), pack1(0));
        check({tag, ".strobe"}, 32'(outNoteOnStrobe), pack1(1));
    endtask

    task automatic cycle(input bit rdy, input logic [7:0] b);
        @(negedge inCLK);
        inMidiReady = rdy;
        inMidiByte  = b;
        @(posedge inCLK);
        model_apply();
        if (rdy) model_byte(int'(b));
        #1;
        check_all("cyc");
    endtask

    task automatic send3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        cycle(1'b1, a); cycle(1'b1, b); cycle(1'b1, c);
    endtask

    task automatic idle();
        cycle(1'b0, 8'h00);
    endtask

    // Reset asserted off-edge so the immediate (asynchronous) clear is observable.
    task automatic do_reset();
        @(negedge inCLK);
        inMidiReady = 1'b0;
        inRESET = 1'b1;
        #1;
        model_reset();
        check_all("rst_async");
        @(posedge inCLK);
        #1;
        @(negedge inCLK);
        inRESET = 1'b0;
    endtask

    initial begin
        int r;
        logic [7:0] b;
        logic [7:0] st_tab [10];
        st_tab = '{8'h92, 8'h82, 8'h92, 8'h82, 8'h91, 8'hC2, 8'hD2, 8'hB2, 8'h8F, 8'hE2};
        model_reset();

        // Basic note-on/off
        do_reset();
        send3(8'h92, 8'h3C, 8'h64); idle();
        check("basic_idx", 32'(outFrequencyIndex[6:0]), 32'h3C);
        check("basic_vel", 32'(outVelocity[6:0]), 32'h64);
        check("basic_strobe", 32'(outNoteOnStrobe), 32'h1);
        idle();
        check("strobe_one_cycle", 32'(outNoteOnStrobe), 32'h0);
        send3(8'h82, 8'h3C, 8'h00); idle();
        check("off_gate", 32'(outPlaying), 32'h0);
        check("off_idx_held", 32'(outFrequencyIndex[6:0]), 32'h3C);

        // Running status, velocity-0 note-off
        do_reset();
        send3(8'h92, 8'h3C, 8'h40); cycle(1'b1, 8'h3E); cycle(1'b1, 8'h50);
        cycle(1'b1, 8'h3C); cycle(1'b1, 8'h00); idle();
        check("rs_play", 32'(outPlaying), 32'h2);
        check("rs_idx1", 32'(outFrequencyIndex[13:7]), 32'h3E);

        // Steal the oldest voice
        do_reset();
        send3(8'h92, 8'h40, 8'h10);
        for (int n = 'h41; n <= 'h44; n++) begin
            cycle(1'b1, 8'(n)); cycle(1'b1, 8'h10);
        end
        idle();
        check("steal_strobe", 32'(outNoteOnStrobe), 32'h1);
        check("steal_idx", 32'(outFrequencyIndex[6:0]), 32'h44);
        cycle(1'b1, 8'h45); cycle(1'b1, 8'h10); idle();
        check("steal2_strobe", 32'(outNoteOnStrobe), 32'h2);

        // Retrigger
        do_reset();
        send3(8'h92, 8'h40, 8'h10); send3(8'h92, 8'h40, 8'h7F); idle();
        check("retrig_strobe", 32'(outNoteOnStrobe), 32'h1);
        check("retrig_vel", 32'(outVelocity[6:0]), 32'h7F);
        check("retrig_play", 32'(outPlaying), 32'h1);

        // Channel filter, interleaved realtime and system common
        do_reset();
        send3(8'h91, 8'h30, 8'h40); idle();
        check("chan_other", 32'(outPlaying), 32'h0);
        cycle(1'b1, 8'h92); cycle(1'b1, 8'h30); cycle(1'b1, 8'hF8); cycle(1'b1, 8'h40); idle();
        check("chan_rt_idx", 32'(outFrequencyIndex[6:0]), 32'h30);
        send3(8'hF0, 8'h31, 8'h40); idle();
        check("sysex_noeffect", 32'(outPlaying), 32'h1);

        // Reset mid-message
        cycle(1'b1, 8'h92);
        do_reset();
        cycle(1'b1, 8'h30); cycle(1'b1, 8'h40); idle();
        check("post_reset_play", 32'(outPlaying), 32'h0);

        // Randomized byte streams against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 599) == 0) do_reset();
            r = $urandom_range(0, 99);
            if (r < 6)       b = 8'(8'hF8 + $urandom_range(0, 7));
            else if (r < 9)  b = 8'(8'hF0 + $urandom_range(0, 7));
            else if (r < 28) b = st_tab[$urandom_range(0, 9)];
            else if (r < 38) b = 8'h00;
            else             b = 8'(8'h38 + $urandom_range(0, 9));
            cycle($urandom_range(0, 9) != 0, b);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
